paddle_ctrl: RTL and testbench

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/paddle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_paddle_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : paddle_ctrl
// Purpose  : Horizontal paddle position controller. Two asynchronous
//            left/right requests are synchronised and sampled once per
//            frame_tick. A three-state FSM (IDLE / MOVE_L / MOVE_R) steps
//            the paddle centre and clamps it to the visible range.
//            Optional hold-to-accelerate is built only when the macro
//            PADDLE_ACCEL_EN is defined. Otherwise every step is STEP_MIN
//            and no held-tick counter exists.
// Ports    : clk        - single clock, rising-edge
//            reset      - asynchronous, active-high
//            move_left  - left request (asynchronous to clk)
//            move_right - right request (asynchronous to clk)
//            frame_tick - one-cycle update strobe
//            paddle_x   - registered paddle centre x coordinate
//            at_left    - paddle_x == X_MIN
//            at_right   - paddle_x == X_MAX
//            speed      - registered step size the next tick applies
// Revision : 1.0 - initial release
// ============================================================================
module paddle_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int PADDLE_W    = 80,
  parameter int X_BITS      = 10,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              move_left,
  input  logic              move_right,
  input  logic              frame_tick,
  output logic [X_BITS-1:0] paddle_x,
  output logic              at_left,
  output logic              at_right,
  output logic [3:0]        speed
);

  // Position limits, in the widened arithmetic width and in output width.
  localparam logic [X_BITS:0]   c_x_min    = (X_BITS+1)'(PADDLE_W / 2);
  localparam logic [X_BITS:0]   c_x_max    = (X_BITS+1)'(SCREEN_W - PADDLE_W / 2);
  localparam logic [X_BITS-1:0] c_x_min_n  = X_BITS'(PADDLE_W / 2);
  localparam logic [X_BITS-1:0] c_x_max_n  = X_BITS'(SCREEN_W - PADDLE_W / 2);
  localparam logic [X_BITS-1:0] c_x_centre = X_BITS'(SCREEN_W / 2);
  localparam logic [3:0]        c_step_min = 4'(STEP_MIN);

  // Held-tick count beyond which speed can no longer grow; the counter
  // saturates there so it never wraps.
  localparam int HELD_MAX = ACCEL_TICKS * (STEP_MAX - STEP_MIN);
  localparam int HELD_W   = (HELD_MAX < 1) ? 1 : $clog2(HELD_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_L = 2'd1,
    ST_MOVE_R = 2'd2
  } state_t;

  // min(STEP_MIN + h/ACCEL_TICKS, STEP_MAX)
  function automatic logic [3:0] speed_for(input logic [HELD_W-1:0] h);
    logic [HELD_W-1:0] incr;
    incr = h / HELD_W'(ACCEL_TICKS);
    if (incr >= HELD_W'(STEP_MAX - STEP_MIN)) begin
      speed_for = 4'(STEP_MAX);
    end else begin
      speed_for = c_step_min + 4'(incr);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Two-flop synchronisers for the asynchronous requests
  // --------------------------------------------------------------------------
  logic r_left_meta, r_left_sync;
  logic r_right_meta, r_right_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left_meta  <= 1'b0;
      r_left_sync  <= 1'b0;
      r_right_meta <= 1'b0;
      r_right_sync <= 1'b0;
    end else begin
      r_left_meta  <= move_left;
      r_left_sync  <= r_left_meta;
      r_right_meta <= move_right;
      r_right_sync <= r_right_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Direction requested this tick: both or neither pressed means stand still
  // --------------------------------------------------------------------------
  state_t w_dir;

  always_comb begin
    w_dir = ST_IDLE;
    if (r_left_sync && !r_right_sync) begin
      w_dir = ST_MOVE_L;
    end else if (r_right_sync && !r_left_sync) begin
      w_dir = ST_MOVE_R;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  state_t r_state, w_state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Step size selection
  // --------------------------------------------------------------------------
  logic [3:0] w_step;        // step applied on this tick
  logic [3:0] w_speed_next;  // step the following tick would apply

`ifdef PADDLE_ACCEL_EN
  logic [HELD_W-1:0] r_held, w_held_prior, w_held_next;

  // A reversal, or a tick out of IDLE, starts counting from zero.
  always_comb begin
    w_held_prior = (w_dir == r_state) ? r_held : '0;
    if (w_dir == ST_IDLE) begin
      w_held_next = '0;
    end else if (w_held_prior == HELD_W'(HELD_MAX)) begin
      w_held_next = w_held_prior;
    end else begin
      w_held_next = w_held_prior + HELD_W'(1);
    end
  end

  assign w_step       = speed_for(w_held_prior);
  assign w_speed_next = (w_dir == ST_IDLE) ? c_step_min : speed_for(w_held_next);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_held <= '0;
    end else if (frame_tick) begin
      r_held <= w_held_next;
    end
  end
`else
  // Fixed speed: a zero held count always yields STEP_MIN.
  assign w_step       = speed_for('0);
  assign w_speed_next = w_step;
`endif

  // --------------------------------------------------------------------------
  // FSM next state and position datapath
  // --------------------------------------------------------------------------
  logic [X_BITS-1:0] r_x, w_x_next;
  logic [X_BITS:0]   w_sum, w_diff;

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    // One extra bit so a left step below zero shows up as a set MSB.
    w_sum        = {1'b0, r_x} + (X_BITS+1)'(w_step);
    w_diff       = {1'b0, r_x} - (X_BITS+1)'(w_step);

    if (frame_tick) begin
      w_state_next = w_dir;
    end

    case (w_dir)
      ST_MOVE_L: begin
        if (w_diff[X_BITS] || (w_diff < c_x_min)) begin
          w_x_next = c_x_min_n;
        end else begin
          w_x_next = w_diff[X_BITS-1:0];
        end
      end
      ST_MOVE_R: begin
        if (w_sum > c_x_max) begin
          w_x_next = c_x_max_n;
        end else begin
          w_x_next = w_sum[X_BITS-1:0];
        end
      end
      default: begin
        w_x_next = r_x;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output registers: change only on the edge that samples frame_tick high
  // --------------------------------------------------------------------------
  logic       r_at_left, r_at_right;
  logic [3:0] r_speed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x        <= c_x_centre;
      r_at_left  <= 1'b0;
      r_at_right <= 1'b0;
      r_speed    <= c_step_min;
    end else if (frame_tick) begin
      r_x        <= w_x_next;
      r_at_left  <= (w_x_next == c_x_min_n);
      r_at_right <= (w_x_next == c_x_max_n);
      r_speed    <= w_speed_next;
    end
  end

  assign paddle_x = r_x;
  assign at_left  = r_at_left;
  assign at_right = r_at_right;
  assign speed    = r_speed;

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_paddle_ctrl
// Purpose  : Scoreboard bench for paddle_ctrl. Stimulus pushes the expected
//            outputs for each tick (or explicit check strobe) into a queue;
//            a monitor pops and compares after every sampled tick.
//            Expected values follow PADDLE_ACCEL_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paddle_ctrl;

  logic       clk;
  logic       reset;
  logic       move_left;
  logic       move_right;
  logic       frame_tick;
  logic [9:0] paddle_x;
  logic       at_left;
  logic       at_right;
  logic [3:0] speed;

  logic       chk_req;
  int         total;
  int         bad;

  typedef struct {
    int   x;
    logic al;
    logic ar;
    int   sp;
    bit   ck;
  } exp_t;

  exp_t sb[$];

  paddle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .move_left  (move_left),
    .move_right (move_right),
    .frame_tick (frame_tick),
    .paddle_x   (paddle_x),
    .at_left    (at_left),
    .at_right   (at_right),
    .speed      (speed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented on every tick edge or explicit check strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_tick || chk_req) begin
        #1;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_underrun: got empty queue expected entry");
        end else begin
          e = sb.pop_front();
          if (e.ck) begin
            cmp("paddle_x", 32'(paddle_x), 32'(e.x));
            cmp("at_left",  32'(at_left),  32'(e.al));
            cmp("at_right", 32'(at_right), 32'(e.ar));
            cmp("speed",    32'(speed),    32'(e.sp));
          end
        end
      end
    end
  end

  // Hold the requests long enough to pass the synchroniser, then tick once.
  task automatic do_tick(input logic l, input logic r, input bit ck,
                         input int x, input logic al, input logic ar, input int sp);
    move_left  = l;
    move_right = r;
    repeat (3) @(negedge clk);
    sb.push_back('{x, al, ar, sp, ck});
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Check outputs on a cycle with no tick.
  task automatic do_chk(input int x, input logic al, input logic ar, input int sp);
    sb.push_back('{x, al, ar, sp, 1'b1});
    chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
  endtask

  task automatic do_reset();
    move_left  = 1'b0;
    move_right = 1'b0;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

`ifdef PADDLE_ACCEL_EN
  int r8_x[8]  = '{321, 322, 323, 324, 326, 328, 330, 332};
  int r8_sp[8] = '{1, 1, 1, 2, 2, 2, 2, 3};
  int r5_x[5]  = '{321, 322, 323, 324, 326};
  int r5_sp[5] = '{1, 1, 1, 2, 2};
  int rv_x[7]  = '{328, 329, 330, 331, 333, 332, 331};
  int rv_sp[7] = '{1, 1, 1, 2, 2, 1, 1};
`else
  int r8_x[8]  = '{321, 322, 323, 324, 325, 326, 327, 328};
  int r8_sp[8] = '{1, 1, 1, 1, 1, 1, 1, 1};
  int r5_x[5]  = '{321, 322, 323, 324, 325};
  int r5_sp[5] = '{1, 1, 1, 1, 1};
  int rv_x[7]  = '{327, 328, 329, 330, 331, 330, 329};
  int rv_sp[7] = '{1, 1, 1, 1, 1, 1, 1};
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    move_left  = 1'b0;
    move_right = 1'b0;
    frame_tick = 1'b0;
    chk_req    = 1'b0;

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    do_chk(320, 1'b0, 1'b0, 1);
    reset = 1'b0;
    @(negedge clk);
    do_chk(320, 1'b0, 1'b0, 1);

    // Hold right for 8 ticks, then a quiet cycle must hold everything
    for (int i = 0; i < 8; i++) do_tick(1'b0, 1'b1, 1'b1, r8_x[i], 1'b0, 1'b0, r8_sp[i]);
    repeat (2) @(negedge clk);
    do_chk(r8_x[7], 1'b0, 1'b0, r8_sp[7]);

    // Reset between ticks while moving: immediate centre, next tick is a fresh start
    reset = 1'b1;
    do_chk(320, 1'b0, 1'b0, 1);
    reset = 1'b0;
    do_tick(1'b0, 1'b1, 1'b1, 321, 1'b0, 1'b0, 1);

    // Right 5, both 1, right 1
    do_reset();
    for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b1, 1'b1, r5_x[i], 1'b0, 1'b0, r5_sp[i]);
    do_tick(1'b1, 1'b1, 1'b1, r5_x[4], 1'b0, 1'b0, 1);
    do_tick(1'b0, 1'b1, 1'b1, r5_x[4] + 1, 1'b0, 1'b0, 1);

    // A request that comes and goes between ticks has no effect
    move_left  = 1'b1;
    move_right = 1'b0;
    repeat (3) @(negedge clk);
    do_tick(1'b0, 1'b0, 1'b1, r5_x[4] + 1, 1'b0, 1'b0, 1);

    // Right 5 then reverse: the reversal restarts at the minimum step
    for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b1, 1'b1, rv_x[i], 1'b0, 1'b0, rv_sp[i]);
    for (int i = 5; i < 7; i++) do_tick(1'b1, 1'b0, 1'b1, rv_x[i], 1'b0, 1'b0, rv_sp[i]);

    // Left edge: clamp at 40 with no wrap
    do_reset();
    for (int i = 1; i <= 300; i++) begin
`ifdef PADDLE_ACCEL_EN
      if (i == 1)        do_tick(1'b1, 1'b0, 1'b1, 319, 1'b0, 1'b0, 1);
      else if (i >= 299) do_tick(1'b1, 1'b0, 1'b1, 40,  1'b1, 1'b0, 8);
      else               do_tick(1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b0, 0);
`else
      if (i == 1)        do_tick(1'b1, 1'b0, 1'b1, 319, 1'b0, 1'b0, 1);
      else if (i == 279) do_tick(1'b1, 1'b0, 1'b1, 41,  1'b0, 1'b0, 1);
      else if (i == 280) do_tick(1'b1, 1'b0, 1'b1, 40,  1'b1, 1'b0, 1);
      else if (i == 300) do_tick(1'b1, 1'b0, 1'b1, 40,  1'b1, 1'b0, 1);
      else               do_tick(1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b0, 0);
`endif
    end

    // Right edge: clamp at 600
    do_reset();
    for (int i = 1; i <= 300; i++) begin
`ifdef PADDLE_ACCEL_EN
      if (i == 1)        do_tick(1'b0, 1'b1, 1'b1, 321, 1'b0, 1'b0, 1);
      else if (i >= 299) do_tick(1'b0, 1'b1, 1'b1, 600, 1'b0, 1'b1, 8);
      else               do_tick(1'b0, 1'b1, 1'b0, 0,   1'b0, 1'b0, 0);
`else
      if (i == 1)        do_tick(1'b0, 1'b1, 1'b1, 321, 1'b0, 1'b0, 1);
      else if (i == 279) do_tick(1'b0, 1'b1, 1'b1, 599, 1'b0, 1'b0, 1);
      else if (i == 280) do_tick(1'b0, 1'b1, 1'b1, 600, 1'b0, 1'b1, 1);
      else if (i == 300) do_tick(1'b0, 1'b1, 1'b1, 600, 1'b0, 1'b1, 1);
      else               do_tick(1'b0, 1'b1, 1'b0, 0,   1'b0, 1'b0, 0);
`endif
    end

    // Both pressed at the edge: stay put, at_right held, speed back to minimum
    do_tick(1'b1, 1'b1, 1'b1, 600, 1'b0, 1'b1, 1);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
